i2c_cfg_sequencer: RTL and testbench



---
 rtl/i2c_cfg_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - power-on I2C configuration sequencer for the pixel-clock oscillator
// Waits out the power-on delay, walks the register/data ROM and hands each entry to
// the I2C write engine over a valid/ready command and response handshake, retrying
// NACKs and timeouts, then releases DDS_START once configuration has settled.
// Ports:
//   CLOCK_IN, RESET         clock, asynchronous active-high reset
//   RESTART                 re-run the table from DONE or ERROR (no power-on delay)
//   ROM_ADDR / ROM_DATA     synchronous table ROM, data valid one cycle after address
//   CMD_VALID / CMD_READY   command handshake, CMD_SLAVE/CMD_REG/CMD_DATA payload
//   RSP_VALID / RSP_ACK     one-cycle transaction result from the engine
//   CFG_DONE, CFG_ERROR     run outcome; DDS_START downstream enable
//   CUR_IDX, RETRY_CNT      progress status
module i2c_cfg_sequencer #(
   parameter int unsigned NUM_REGS       = 11,
   parameter logic [6:0]  SLAVE_ADDR     = 7'h55,
   parameter int unsigned STARTUP_DELAY  = 90000000,
   parameter int unsigned POST_DELAY     = 150000000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned BACKOFF_CYCLES = 4000,
   parameter int unsigned RSP_TIMEOUT    = 100000
) (
   input  logic        CLOCK_IN,
   input  logic        RESET,
   input  logic        RESTART,
   output logic [7:0]  ROM_ADDR,
   input  logic [15:0] ROM_DATA,
   output logic        CMD_VALID,
   input  logic        CMD_READY,
   output logic [6:0]  CMD_SLAVE,
   output logic [7:0]  CMD_REG,
   output logic [7:0]  CMD_DATA,
   input  logic        RSP_VALID,
   input  logic        RSP_ACK,
   output logic        CFG_DONE,
   output logic        CFG_ERROR,
   output logic        DDS_START,
   output logic [7:0]  CUR_IDX,
   output logic [3:0]  RETRY_CNT
);

   typedef enum logic [3:0] {
      S_POR_WAIT, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_RSP,
      S_BACKOFF, S_POST_WAIT, S_DONE, S_ERROR
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt, cnt_inc;
   logic [7:0]  cur_idx, cur_idx_nxt;
   logic [3:0]  retry_cnt, retry_nxt;
   logic [7:0]  cmd_reg, cmd_reg_nxt;
   logic [7:0]  cmd_data, cmd_data_nxt;
   logic        cmd_valid, cmd_valid_nxt;
   logic        cfg_done, done_nxt;
   logic        cfg_error, error_nxt;
   logic        dds_start, dds_nxt;
   logic        rsp_fail;

   // True on the last cycle of an n-cycle wait; a zero-length wait still takes one cycle.
   function automatic logic at_terminal(input logic [31:0] c, input int unsigned n);
      return ({1'b0, c} + 33'd1) >= 33'(n);
   endfunction

   always_ff @(posedge CLOCK_IN or posedge RESET) begin
      if (RESET) begin
         state     <= S_POR_WAIT;
         cnt       <= '0;
         cur_idx   <= '0;
         retry_cnt <= '0;
         cmd_reg   <= '0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_error <= 1'b0;
         dds_start <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         cur_idx   <= cur_idx_nxt;
         retry_cnt <= retry_nxt;
         cmd_reg   <= cmd_reg_nxt;
         cmd_data  <= cmd_data_nxt;
         cmd_valid <= cmd_valid_nxt;
         cfg_done  <= done_nxt;
         cfg_error <= error_nxt;
         dds_start <= dds_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cur_idx_nxt   = cur_idx;
      retry_nxt     = retry_cnt;
      cmd_reg_nxt   = cmd_reg;
      cmd_data_nxt  = cmd_data;
      cmd_valid_nxt = cmd_valid;
      done_nxt      = cfg_done;
      error_nxt     = cfg_error;
      dds_nxt       = dds_start;
      // A response on the timeout cycle wins over the timeout itself.
      rsp_fail      = (RSP_VALID && !RSP_ACK) ||
                      (!RSP_VALID && at_terminal(cnt, RSP_TIMEOUT));
      case (state)
         S_POR_WAIT: if (at_terminal(cnt, STARTUP_DELAY)) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_LATCH;
         S_LATCH: begin
            cmd_reg_nxt   = ROM_DATA[15:8];
            cmd_data_nxt  = ROM_DATA[7:0];
            cmd_valid_nxt = 1'b1;
            state_nxt     = S_ISSUE;
         end
         S_ISSUE: begin
            if (CMD_READY) begin
               cmd_valid_nxt = 1'b0;
               state_nxt     = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (RSP_VALID && RSP_ACK) begin
               if (cur_idx == LAST_IDX) begin
                  state_nxt = S_POST_WAIT;
               end else begin
                  cur_idx_nxt = cur_idx + 8'd1;
                  retry_nxt   = '0;
                  state_nxt   = S_FETCH;
               end
            end else if (rsp_fail) begin
               if (32'(retry_cnt) < MAX_RETRY) begin
                  retry_nxt = retry_cnt + 4'd1;
                  state_nxt = S_BACKOFF;
               end else begin
                  error_nxt = 1'b1;
                  state_nxt = S_ERROR;
               end
            end
         end
         // The latched command is reissued unchanged; no ROM re-fetch.
         S_BACKOFF: begin
            if (at_terminal(cnt, BACKOFF_CYCLES)) begin
               cmd_valid_nxt = 1'b1;
               state_nxt     = S_ISSUE;
            end
         end
         S_POST_WAIT: begin
            if (at_terminal(cnt, POST_DELAY)) begin
               done_nxt  = 1'b1;
               dds_nxt   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE, S_ERROR: begin
            if (RESTART) begin
               done_nxt    = 1'b0;
               error_nxt   = 1'b0;
               dds_nxt     = 1'b0;
               cur_idx_nxt = '0;
               retry_nxt   = '0;
               state_nxt   = S_FETCH;
            end
         end
         default: state_nxt = S_POR_WAIT;
      endcase
      // One shared saturating counter, restarted on every state change.
      cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
      cnt_nxt = (state_nxt != state) ? 32'd0 : cnt_inc;
   end

   assign ROM_ADDR  = cur_idx;
   assign CMD_VALID = cmd_valid;
   assign CMD_SLAVE = SLAVE_ADDR;
   assign CMD_REG   = cmd_reg;
   assign CMD_DATA  = cmd_data;
   assign CFG_DONE  = cfg_done;
   assign CFG_ERROR = cfg_error;
   assign DDS_START = dds_start;
   assign CUR_IDX   = cur_idx;
   assign RETRY_CNT = retry_cnt;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - randomized self-checking bench for i2c_cfg_sequencer
module tb_i2c_cfg_sequencer;

   localparam int NR = 3;
   localparam int SD = 10;
   localparam int PD = 20;
   localparam int MR = 3;
   localparam int BO = 4;
   localparam int RT = 50;

   localparam int K_ACK = 0, K_NACK = 1, K_TMO = 2, K_TMO_ACK = 3;

   logic        CLOCK_IN = 1'b0;
   logic        RESET, RESTART, CMD_READY, RSP_VALID, RSP_ACK;
   logic [15:0] ROM_DATA;
   logic [7:0]  ROM_ADDR, CMD_REG, CMD_DATA, CUR_IDX;
   logic [6:0]  CMD_SLAVE;
   logic [3:0]  RETRY_CNT;
   logic        CMD_VALID, CFG_DONE, CFG_ERROR, DDS_START;

   logic [15:0] rom [0:3];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   i2c_cfg_sequencer #(
      .NUM_REGS(NR), .SLAVE_ADDR(7'h55), .STARTUP_DELAY(SD), .POST_DELAY(PD),
      .MAX_RETRY(MR), .BACKOFF_CYCLES(BO), .RSP_TIMEOUT(RT)
   ) dut (
      .CLOCK_IN(CLOCK_IN), .RESET(RESET), .RESTART(RESTART),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_SLAVE(CMD_SLAVE),
      .CMD_REG(CMD_REG), .CMD_DATA(CMD_DATA),
      .RSP_VALID(RSP_VALID), .RSP_ACK(RSP_ACK),
      .CFG_DONE(CFG_DONE), .CFG_ERROR(CFG_ERROR), .DDS_START(DDS_START),
      .CUR_IDX(CUR_IDX), .RETRY_CNT(RETRY_CNT)
   );

   always #5 CLOCK_IN = ~CLOCK_IN;

   always_ff @(posedge CLOCK_IN) ROM_DATA <= rom[ROM_ADDR[1:0]];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge CLOCK_IN);
      #1;
      cyc++;
   endtask

   task automatic drive_noise(input bit en);
      if (en) begin
         RSP_VALID = 1'($urandom_range(0, 1));
         RSP_ACK   = 1'($urandom_range(0, 1));
         RESTART   = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic clear_noise;
      RSP_VALID = 1'b0;
      RSP_ACK   = 1'b0;
      RESTART   = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq(tag, 64'({CMD_VALID, CMD_SLAVE, CMD_REG, CMD_DATA, ROM_ADDR, CUR_IDX,
                         RETRY_CNT, CFG_DONE, CFG_ERROR, DDS_START}),
               64'({1'b0, 7'h55, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0}));
   endtask

   initial begin
      int exp_issue, idx, retry, e_cyc, h_cyc, kind, rdly, d, n;
      bit finished, abort, did_reset, noisy, ok, rsp_ok;
      rom[0] = 16'h8400; rom[1] = 16'h0023; rom[2] = 16'h05B0; rom[3] = 16'h0000;
      RESET = 1'b1; CMD_READY = 1'b0;
      clear_noise();
      abort = 1'b0;
      repeat (3) tick();
      check_reset_vals("reset_state");
      RESET = 1'b0;
      exp_issue = cyc + SD + 2;

      for (int run = 0; run < 10; run++) begin
         if (abort) break;
         idx = 0; retry = 0; finished = 1'b0; did_reset = 1'b0;
         noisy = (run >= 5);
         while (!finished && !abort) begin
            n = 0;
            while (!CMD_VALID && n < 100) begin
               drive_noise(noisy);
               tick();
               n++;
            end
            clear_noise();
            check_eq("issue_cycle", 64'(cyc), 64'(exp_issue));
            if (!CMD_VALID) begin
               abort = 1'b1;
               break;
            end
            check_eq("cmd_fields", 64'({CMD_SLAVE, CMD_REG, CMD_DATA}), 64'({7'h55, rom[idx]}));
            check_eq("cur_idx_at_issue", 64'(CUR_IDX), 64'(idx));
            check_eq("retry_at_issue", 64'(RETRY_CNT), 64'(retry));

            rdly = (run == 1 && idx == 1 && retry == 0) ? 7 :
                   (run >= 5) ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < rdly; k++) begin
               tick();
               check_eq("hold_stable", 64'({CMD_VALID, CMD_SLAVE, CMD_REG, CMD_DATA}),
                        64'({1'b1, 7'h55, rom[idx]}));
            end
            CMD_READY = 1'b1;
            tick();
            CMD_READY = 1'b0;
            h_cyc = cyc;
            check_eq("valid_drop", 64'(CMD_VALID), 64'(0));

            if (run == 4 && idx == 1 && !did_reset) begin
               #3;
               RESET = 1'b1;
               #1;
               check_reset_vals("async_reset");
               tick();
               tick();
               RESET = 1'b0;
               exp_issue = cyc + SD + 2;
               idx = 0; retry = 0; did_reset = 1'b1;
               continue;
            end

            case (run)
               1: kind = (idx == 1 && retry < 2) ? K_NACK : K_ACK;
               2: kind = (idx == 2) ? K_NACK : K_ACK;
               3: kind = (idx == 0 && retry == 0) ? K_TMO : (idx == 1 ? K_TMO_ACK : K_ACK);
               default: begin
                  if (run >= 5) begin
                     n = int'($urandom_range(0, 9));
                     kind = (n < 6) ? K_ACK : (n < 8) ? K_NACK : (n == 8) ? K_TMO : K_TMO_ACK;
                  end else begin
                     kind = K_ACK;
                  end
               end
            endcase
            d = (run >= 5) ? int'($urandom_range(1, 8)) : 2;
            ok = (kind == K_ACK || kind == K_TMO_ACK);
            if (kind == K_TMO) begin
               repeat (RT) tick();
            end else begin
               if (kind == K_TMO_ACK) d = RT;
               rsp_ok = (kind != K_NACK);
               for (int k = 1; k <= d; k++) begin
                  RSP_VALID = (k == d);
                  RSP_ACK   = rsp_ok && (k == d);
                  tick();
               end
               clear_noise();
            end
            e_cyc = h_cyc + ((kind == K_TMO || kind == K_TMO_ACK) ? RT : d);

            if (ok) begin
               if (idx == NR - 1) begin
                  finished = 1'b1;
                  n = 0;
                  while (!DDS_START && n < PD + 10) begin
                     drive_noise(noisy);
                     tick();
                     n++;
                  end
                  clear_noise();
                  check_eq("dds_start_cycle", 64'(cyc), 64'(e_cyc + PD));
                  check_eq("done_flags", 64'({CFG_DONE, CFG_ERROR, DDS_START, CMD_VALID}),
                           64'(4'b1010));
                  if (!DDS_START) abort = 1'b1;
               end else begin
                  idx++;
                  retry = 0;
                  exp_issue = e_cyc + 2;
               end
            end else if (retry < MR) begin
               retry++;
               exp_issue = e_cyc + BO;
            end else begin
               finished = 1'b1;
               check_eq("error_flags", 64'({CFG_ERROR, CFG_DONE, DDS_START}), 64'(3'b100));
               check_eq("error_idx", 64'(CUR_IDX), 64'(idx));
               repeat (5) tick();
               check_eq("error_idle", 64'({CFG_ERROR, CMD_VALID, DDS_START}), 64'(3'b100));
            end
         end

         if (!abort && run < 9) begin
            if (run + 1 >= 5) begin
               for (int i = 0; i < NR; i++) rom[i] = 16'($urandom);
            end
            RESTART = 1'b1;
            tick();
            RESTART = 1'b0;
            check_eq("restart_clear", 64'({CUR_IDX, RETRY_CNT, CFG_DONE, CFG_ERROR, DDS_START}),
                     64'(0));
            exp_issue = cyc + 2;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
